// File: rtl/mem_port0_arbiter.sv
// Round-robin arbiter sharing RAM port 0 between requesters A and B, with read-valid tracking.
// Optional power-up clear sweep of the whole RAM when MEM_ARB_CLEAR_EN is defined.
module mem_port0_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned WORD  = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_req,
  input  logic             a_we,
  input  logic [31:0]      a_addr,
  input  logic [WIDTH-1:0] a_wdata,
  output logic             a_gnt,
  output logic             a_rvalid,
  output logic [WIDTH-1:0] a_rdata,
  input  logic             b_req,
  input  logic             b_we,
  input  logic [31:0]      b_addr,
  input  logic [WIDTH-1:0] b_wdata,
  output logic             b_gnt,
  output logic             b_rvalid,
  output logic [WIDTH-1:0] b_rdata,
  output logic [31:0]      m_addr0,
  output logic [WIDTH-1:0] m_in0,
  output logic             m_we0,
  input  logic [WIDTH-1:0] m_out0,
  output logic             busy
);

  localparam int unsigned CntW = (WORD > 1) ? $clog2(WORD) : 1;

  logic        last_b_q, last_b_d;
  logic        a_pend_q, a_pend_d;
  logic        b_pend_q, b_pend_d;
  logic        run;
  logic        clearing;
  logic [31:0] clr_addr;

`ifdef MEM_ARB_CLEAR_EN
  typedef enum logic [0:0] {StClear, StRun} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == StClear) begin
      cnt_d = cnt_q + CntW'(1);
      if (cnt_q == CntW'(WORD - 1)) begin
        state_d = StRun;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StClear;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign run      = (state_q == StRun) && !rst;
  assign clearing = (state_q == StClear) && !rst;
  assign clr_addr = 32'(cnt_q);
  assign busy     = (state_q == StClear);
`else
  assign run      = !rst;
  assign clearing = 1'b0;
  assign clr_addr = '0;
  assign busy     = 1'b0;
`endif

  always_comb begin
    a_gnt    = 1'b0;
    b_gnt    = 1'b0;
    m_addr0  = '0;
    m_in0    = '0;
    m_we0    = 1'b0;
    last_b_d = last_b_q;
    if (clearing) begin
      m_we0   = 1'b1;
      m_addr0 = clr_addr;
    end else if (run) begin
      // On a tie, the requester that did not win last time goes first.
      if (a_req && (!b_req || last_b_q)) begin
        a_gnt = 1'b1;
      end else if (b_req) begin
        b_gnt = 1'b1;
      end
      if (a_gnt) begin
        m_addr0  = a_addr;
        m_in0    = a_wdata;
        m_we0    = a_we;
        last_b_d = 1'b0;
      end else if (b_gnt) begin
        m_addr0  = b_addr;
        m_in0    = b_wdata;
        m_we0    = b_we;
        last_b_d = 1'b1;
      end
    end
    a_pend_d = a_gnt && !a_we;
    b_pend_d = b_gnt && !b_we;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_b_q <= 1'b1;
      a_pend_q <= 1'b0;
      b_pend_q <= 1'b0;
    end else begin
      last_b_q <= last_b_d;
      a_pend_q <= a_pend_d;
      b_pend_q <= b_pend_d;
    end
  end

  // A read in flight when reset arrives is suppressed in the reset cycle.
  assign a_rvalid = a_pend_q && !rst;
  assign b_rvalid = b_pend_q && !rst;
  assign a_rdata  = m_out0;
  assign b_rdata  = m_out0;

endmodule

// File: tb/tb_mem_port0_arbiter.sv
// Directed self-checking bench for mem_port0_arbiter with a small registered RAM model.
// Clear-sweep scenarios are compiled in only when MEM_ARB_CLEAR_EN is defined.
module tb_mem_port0_arbiter;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned WORD  = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [31:0]      a_addr = '0, b_addr = '0;
  logic [WIDTH-1:0] a_wdata = '0, b_wdata = '0;
  logic             a_gnt, a_rvalid, b_gnt, b_rvalid, m_we0, busy;
  logic [WIDTH-1:0] a_rdata, b_rdata, m_in0, m_out0;
  logic [31:0]      m_addr0;
  int               total = 0;
  int               bad = 0;
  logic [WIDTH-1:0] ram [WORD];

  mem_port0_arbiter #(.WIDTH(WIDTH), .WORD(WORD)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .m_addr0(m_addr0), .m_in0(m_in0), .m_we0(m_we0), .m_out0(m_out0), .busy(busy)
  );

  always #5 clk = ~clk;

  // Read-before-write RAM port 0 with one-cycle registered read.
  always @(posedge clk) begin
    if (m_we0) ram[m_addr0[3:0]] <= m_in0;
    m_out0 <= ram[m_addr0[3:0]];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic samp;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; a_req = 1'b1; b_req = 1'b1; a_we = 1'b0; b_we = 1'b1;
    tick(); tick(); samp();
    total++; if (a_gnt !== 1'b0) begin bad++; $display("FAIL rst_a_gnt got=%0b want=0", a_gnt); end
    total++; if (b_gnt !== 1'b0) begin bad++; $display("FAIL rst_b_gnt got=%0b want=0", b_gnt); end
    total++; if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin
      bad++; $display("FAIL rst_rvalid got=%0b%0b want=00", a_rvalid, b_rvalid); end
    total++; if (m_we0 !== 1'b0) begin bad++; $display("FAIL rst_m_we0 got=%0b want=0", m_we0); end
    tick();
    rst = 1'b0;
`ifndef MEM_ARB_CLEAR_EN
    b_we = 1'b0;
    samp();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b want=0", busy); end
    total++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
      bad++; $display("FAIL rst_first_tie got=%0b%0b want=10", a_gnt, b_gnt); end
    tick();
    a_req = 1'b0; b_req = 1'b0;
`endif
  endtask

`ifdef MEM_ARB_CLEAR_EN
  task automatic test_clear_sweep;
    for (int i = 0; i < 16; i++) begin
      samp();
      total++; if (busy !== 1'b1 || m_we0 !== 1'b1 || m_addr0 !== 32'(i) || m_in0 !== '0) begin
        bad++; $display("FAIL sweep_%0d got busy=%0b we=%0b addr=%0d data=%h want 1 1 %0d 0",
                        i, busy, m_we0, m_addr0, m_in0, i); end
      total++; if (a_gnt !== 1'b0 || b_gnt !== 1'b0) begin
        bad++; $display("FAIL sweep_gnt_%0d got=%0b%0b want=00", i, a_gnt, b_gnt); end
      tick();
    end
    b_req = 1'b0; b_we = 1'b0; a_we = 1'b0; a_addr = 32'd3;
    samp();
    total++; if (busy !== 1'b0 || a_gnt !== 1'b1) begin
      bad++; $display("FAIL sweep_done got busy=%0b a_gnt=%0b want 0 1", busy, a_gnt); end
    tick();
    a_req = 1'b0;
    samp();
    total++; if (a_rvalid !== 1'b1 || a_rdata !== 32'h0) begin
      bad++; $display("FAIL sweep_read3 got v=%0b d=%h want 1 0", a_rvalid, a_rdata); end
    tick();
  endtask

  task automatic test_clear_restart;
    int n;
    rst = 1'b1; a_req = 1'b0; b_req = 1'b0;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    samp();
    total++; if (m_addr0 !== 32'd9) begin
      bad++; $display("FAIL restart_at9 got=%0d want=9", m_addr0); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    samp();
    total++; if (m_addr0 !== 32'd0 || busy !== 1'b1) begin
      bad++; $display("FAIL restart_addr0 got addr=%0d busy=%0b want 0 1", m_addr0, busy); end
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      tick(); samp();
    end
    total++; if (n != 16) begin bad++; $display("FAIL restart_busy_len got=%0d want=16", n); end
    tick();
  endtask
`endif

  task automatic test_single_read;
    a_req = 1'b1; a_we = 1'b1; a_addr = 32'd5; a_wdata = 32'h1234; b_req = 1'b0;
    samp();
    total++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0 || m_we0 !== 1'b1 || m_addr0 !== 32'd5 ||
                 m_in0 !== 32'h1234) begin
      bad++; $display("FAIL t1_write got gnt=%0b%0b we=%0b addr=%0d d=%h want 10 1 5 1234",
                      a_gnt, b_gnt, m_we0, m_addr0, m_in0); end
    tick();
    a_we = 1'b0;
    samp();
    total++; if (a_gnt !== 1'b1 || m_we0 !== 1'b0 || a_rvalid !== 1'b0) begin
      bad++; $display("FAIL t1_read got gnt=%0b we=%0b rv=%0b want 1 0 0", a_gnt, m_we0, a_rvalid); end
    tick();
    a_req = 1'b0;
    samp();
    total++; if (a_rvalid !== 1'b1 || a_rdata !== 32'h1234 || b_rvalid !== 1'b0) begin
      bad++; $display("FAIL t1_rdata got rv=%0b d=%h brv=%0b want 1 1234 0", a_rvalid, a_rdata,
                      b_rvalid); end
    total++; if (m_we0 !== 1'b0 || m_addr0 !== 32'd0 || m_in0 !== '0) begin
      bad++; $display("FAIL t1_idle got we=%0b addr=%0d d=%h want 0 0 0", m_we0, m_addr0, m_in0); end
    tick();
  endtask

  task automatic test_round_robin;
    logic exp_a;
    b_req = 1'b1; b_we = 1'b1; b_addr = 32'd9; b_wdata = 32'h55;
    samp();
    total++; if (b_gnt !== 1'b1) begin bad++; $display("FAIL rr_bwrite got=%0b want=1", b_gnt); end
    tick();
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'd5; b_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      samp();
      exp_a = (i % 2 == 0);
      total++; if (a_gnt !== exp_a || b_gnt !== !exp_a) begin
        bad++; $display("FAIL rr_gnt_%0d got=%0b%0b want=%0b%0b", i, a_gnt, b_gnt, exp_a, !exp_a); end
      total++; if (a_rvalid !== (i % 2 == 1) || b_rvalid !== (i == 2)) begin
        bad++; $display("FAIL rr_rvalid_%0d got=%0b%0b want=%0b%0b", i, a_rvalid, b_rvalid,
                        (i % 2 == 1), (i == 2)); end
      if (i == 1) begin
        total++; if (a_rdata !== 32'h1234) begin
          bad++; $display("FAIL rr_ardata got=%h want=1234", a_rdata); end
      end
      if (i == 2) begin
        total++; if (b_rdata !== 32'h55) begin
          bad++; $display("FAIL rr_brdata got=%h want=55", b_rdata); end
      end
      tick();
    end
    a_req = 1'b0; b_req = 1'b0;
    samp();
    total++; if (b_rvalid !== 1'b1 || b_rdata !== 32'h55 || a_rvalid !== 1'b0) begin
      bad++; $display("FAIL rr_tail got brv=%0b d=%h arv=%0b want 1 55 0", b_rvalid, b_rdata,
                      a_rvalid); end
    tick();
  endtask

  task automatic test_back_to_back;
    b_req = 1'b1; b_we = 1'b1; b_addr = 32'd7; b_wdata = 32'hDEAD;
    samp();
    total++; if (b_gnt !== 1'b1 || a_gnt !== 1'b0) begin
      bad++; $display("FAIL b2b_bw got=%0b%0b want=01", a_gnt, b_gnt); end
    tick();
    b_req = 1'b0; a_req = 1'b1; a_we = 1'b0; a_addr = 32'd7;
    samp();
    total++; if (a_gnt !== 1'b1 || b_rvalid !== 1'b0) begin
      bad++; $display("FAIL b2b_ar got gnt=%0b brv=%0b want 1 0", a_gnt, b_rvalid); end
    tick();
    samp();
    total++; if (a_rvalid !== 1'b1 || a_rdata !== 32'hDEAD || b_rvalid !== 1'b0 || a_gnt !== 1'b1) begin
      bad++; $display("FAIL b2b_dead got rv=%0b d=%h brv=%0b gnt=%0b want 1 dead 0 1", a_rvalid,
                      a_rdata, b_rvalid, a_gnt); end
    tick();
    a_req = 1'b0; b_req = 1'b1; b_we = 1'b1; b_addr = 32'd7; b_wdata = 32'hBEEF;
    samp();
    total++; if (b_gnt !== 1'b1 || a_rvalid !== 1'b1 || a_rdata !== 32'hDEAD) begin
      bad++; $display("FAIL b2b_rbw got bgnt=%0b rv=%0b d=%h want 1 1 dead", b_gnt, a_rvalid,
                      a_rdata); end
    tick();
    b_req = 1'b0; a_req = 1'b1;
    samp();
    total++; if (a_gnt !== 1'b1 || b_rvalid !== 1'b0) begin
      bad++; $display("FAIL b2b_ar2 got gnt=%0b brv=%0b want 1 0", a_gnt, b_rvalid); end
    tick();
    a_req = 1'b0;
    samp();
    total++; if (a_rvalid !== 1'b1 || a_rdata !== 32'hBEEF) begin
      bad++; $display("FAIL b2b_beef got rv=%0b d=%h want 1 beef", a_rvalid, a_rdata); end
    tick();
  endtask

  task automatic test_reset_midop;
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'd5;
    samp();
    total++; if (a_gnt !== 1'b1) begin bad++; $display("FAIL mid_gnt got=%0b want=1", a_gnt); end
    tick();
    rst = 1'b1; b_req = 1'b1; b_we = 1'b0; b_addr = 32'd9;
    samp();
    total++; if (a_rvalid !== 1'b0 || a_gnt !== 1'b0 || b_gnt !== 1'b0 || m_we0 !== 1'b0) begin
      bad++; $display("FAIL mid_rst got rv=%0b gnt=%0b%0b we=%0b want 0 00 0", a_rvalid, a_gnt,
                      b_gnt, m_we0); end
    tick();
    rst = 1'b0;
    samp();
`ifdef MEM_ARB_CLEAR_EN
    begin
      int n;
      n = 0;
      while (busy === 1'b1 && n < 40) begin
        n++;
        tick(); samp();
      end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_sweep_end got=%0b want=0", busy); end
    end
`endif
    total++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0 || a_rvalid !== 1'b0) begin
      bad++; $display("FAIL mid_tie got gnt=%0b%0b rv=%0b want 10 0", a_gnt, b_gnt, a_rvalid); end
    tick();
    a_req = 1'b0; b_req = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
`ifdef MEM_ARB_CLEAR_EN
    test_clear_sweep();
`endif
    test_single_read();
    test_round_robin();
    test_back_to_back();
    test_reset_midop();
`ifdef MEM_ARB_CLEAR_EN
    test_clear_restart();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
